// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle RV32I-subset control path:
// FSM states, opcodes, ALU codes and datapath mux encodings.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_JALWB,
      S_TRAP
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;
   localparam logic [2:0] F3_BEQ    = 3'b000;
   localparam logic [2:0] F3_WORD   = 3'b010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic alu_funct3_ok(input logic [2:0] f3);
      return (f3 == F3_ADDSUB) || (f3 == F3_SLT) || (f3 == F3_OR) || (f3 == F3_AND);
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: maps alu_op/funct fields to the 3-bit ALU code and
// flags funct3 values the ALU cannot execute.
module alu_decoder
   import multicycle_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control,
   output logic       illegal
);

   // illegal is independent of alu_op so DECODE can vet funct3 ahead of EXEC.
   assign illegal = !alu_funct3_ok(funct3);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               F3_ADDSUB: alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               F3_SLT:    alu_control = ALU_SLT;
               F3_OR:     alu_control = ALU_OR;
               F3_AND:    alu_control = ALU_AND;
               default:   alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle core: sequences fetch, decode, execute,
// memory and writeback through the shared ALU and unified memory port.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int unsigned RESET_WAIT = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       trap
);

   localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT - 1);

   state_e     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic [1:0] alu_op;
   logic       funct_illegal;
   logic       dec_legal;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (opcode[5]),
      .alu_control (alu_control),
      .illegal     (funct_illegal)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      case (opcode)
         OP_LOAD, OP_STORE: dec_legal = (funct3 == F3_WORD);
         OP_RTYPE, OP_ITYPE: dec_legal = !funct_illegal;
         OP_BRANCH: dec_legal = (funct3 == F3_BEQ);
         OP_JAL: dec_legal = 1'b1;
         default: dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      result_src = RES_ALUOUT;
      imm_src    = IMM_I;
      alu_op     = ALUOP_ADD;
      trap       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (wait_q == WAIT_LAST) begin
               wait_d  = '0;
               state_d = S_FETCH;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target OldPC + immB is parked in ALUOut for BEQ.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_B;
            if (!dec_legal) begin
               state_d = S_TRAP;
            end else begin
               case (opcode)
                  OP_LOAD, OP_STORE: state_d = S_MEMADR;
                  OP_RTYPE:          state_d = S_EXECR;
                  OP_ITYPE:          state_d = S_EXECI;
                  OP_BRANCH:         state_d = S_BEQ;
                  OP_JAL:            state_d = S_JAL;
                  default:           state_d = S_TRAP;
               endcase
            end
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = opcode[5] ? IMM_S : IMM_I;
            state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req    = 1'b1;
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req    = 1'b1;
            mem_write  = 1'b1;
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_I;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALUOUT;
            pc_write   = zero;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
            state_d    = S_JALWB;
         end
         S_JALWB: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_TRAP: begin
            trap    = 1'b1;
            state_d = S_TRAP;
         end
         default: state_d = S_TRAP;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: every cycle compares the full
// output bundle against a hand-built expected vector.
module tb_multicycle_control;

   logic       clk;
   logic       resetn;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
   logic [2:0] alu_control;

   int unsigned checks;
   int unsigned failures;

   multicycle_control #(.RESET_WAIT(1)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_write   (mem_write),
      .adr_src     (adr_src),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .result_src  (result_src),
      .imm_src     (imm_src),
      .alu_control (alu_control),
      .trap        (trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [17:0] outs;
   assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, imm_src, alu_control, trap};

   function automatic logic [17:0] ev(input logic req, input logic wr, input logic asrc,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] rs, input logic [1:0] is,
                                      input logic [2:0] ac, input logic tr);
      return {req, wr, asrc, irw, pcw, rw, sa, sb, rs, is, ac, tr};
   endfunction

   localparam logic [17:0] E_ZERO = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Sample the current state's outputs mid-cycle, then advance one clock.
   task automatic cyc(input string tag, input logic [17:0] exp);
      @(negedge clk);
      check_eq(tag, 32'(outs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      opcode   = op;
      funct3   = f3;
      funct7b5 = f7;
   endtask

   logic [17:0] e_fetch, e_decode, e_aluwb, e_memread, e_memwb, e_memwrite;
   logic [17:0] e_jal, e_jalwb, e_trap;

   initial begin
      checks    = 0;
      failures  = 0;
      resetn    = 1'b0;
      mem_ready = 1'b1;
      zero      = 1'b0;
      set_instr(7'b0110011, 3'b000, 1'b1);

      e_fetch    = ev(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000,0);
      e_decode   = ev(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000,0);
      e_aluwb    = ev(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000,0);
      e_memread  = ev(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0);
      e_memwb    = ev(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 3'b000,0);
      e_memwrite = ev(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0);
      e_jal      = ev(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 3'b000,0);
      e_jalwb    = ev(0,0,0,0,0,1, 2'b01,2'b10,2'b10,2'b00, 3'b000,0);
      e_trap     = ev(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,1);

      #1;
      for (int i = 0; i < 3; i++) cyc("reset", E_ZERO);
      resetn = 1'b1;
      cyc("idle", E_ZERO);

      // R-type sub then add
      cyc("sub_fetch", e_fetch);
      cyc("sub_decode", e_decode);
      cyc("sub_execr", ev(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b001,0));
      cyc("sub_aluwb", e_aluwb);
      set_instr(7'b0110011, 3'b000, 1'b0);
      cyc("add_fetch", e_fetch);
      cyc("add_decode", e_decode);
      cyc("add_execr", ev(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b000,0));
      cyc("add_aluwb", e_aluwb);

      // addi with funct7b5 set must still add; ori maps to or
      set_instr(7'b0010011, 3'b000, 1'b1);
      cyc("addi_fetch", e_fetch);
      cyc("addi_decode", e_decode);
      cyc("addi_execi", ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000,0));
      cyc("addi_aluwb", e_aluwb);
      set_instr(7'b0010011, 3'b110, 1'b0);
      cyc("ori_fetch", e_fetch);
      cyc("ori_decode", e_decode);
      cyc("ori_execi", ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b011,0));
      cyc("ori_aluwb", e_aluwb);

      // lw with two wait states
      set_instr(7'b0000011, 3'b010, 1'b0);
      cyc("lw_fetch", e_fetch);
      cyc("lw_decode", e_decode);
      cyc("lw_memadr", ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000,0));
      mem_ready = 1'b0;
      cyc("lw_memread0", e_memread);
      cyc("lw_memread1", e_memread);
      mem_ready = 1'b1;
      cyc("lw_memread2", e_memread);
      cyc("lw_memwb", e_memwb);

      // beq taken, then not taken
      set_instr(7'b1100011, 3'b000, 1'b0);
      zero = 1'b1;
      cyc("beqt_fetch", e_fetch);
      cyc("beqt_decode", e_decode);
      cyc("beqt_beq", ev(0,0,0,0,1,0, 2'b10,2'b00,2'b00,2'b00, 3'b001,0));
      zero = 1'b0;
      cyc("beqn_fetch", e_fetch);
      cyc("beqn_decode", e_decode);
      cyc("beqn_beq", ev(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b001,0));

      // jal
      set_instr(7'b1101111, 3'b000, 1'b0);
      cyc("jal_fetch", e_fetch);
      cyc("jal_decode", e_decode);
      cyc("jal_jal", e_jal);
      cyc("jal_jalwb", e_jalwb);

      // sw, reset asserted while MEMWRITE is held
      set_instr(7'b0100011, 3'b010, 1'b0);
      cyc("sw_fetch", e_fetch);
      cyc("sw_decode", e_decode);
      cyc("sw_memadr", ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000,0));
      mem_ready = 1'b0;
      cyc("sw_memwrite0", e_memwrite);
      #2;
      check_eq("sw_hold_req", 32'({mem_req, mem_write}), 32'b11);
      resetn = 1'b0;
      #1;
      check_eq("sw_async_drop", 32'({mem_req, mem_write}), 32'b00);
      check_eq("sw_async_all", 32'(outs), 32'(E_ZERO));
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      resetn    = 1'b1;
      cyc("sw_rst_idle", E_ZERO);

      // illegal opcode traps and stays trapped
      set_instr(7'b0110111, 3'b000, 1'b0);
      cyc("ill_fetch", e_fetch);
      cyc("ill_decode", e_decode);
      for (int i = 0; i < 10; i++) cyc("ill_trap", e_trap);
      resetn = 1'b0;
      #1;
      check_eq("trap_async_clear", 32'(outs), 32'(E_ZERO));
      cyc("trap_reset", E_ZERO);
      resetn = 1'b1;
      cyc("trap_idle", E_ZERO);

      // bad funct3 on R-type and on lw both trap from DECODE
      set_instr(7'b0110011, 3'b001, 1'b0);
      cyc("rf3_fetch", e_fetch);
      cyc("rf3_decode", e_decode);
      cyc("rf3_trap", e_trap);
      resetn = 1'b0;
      cyc("rf3_reset", E_ZERO);
      resetn = 1'b1;
      cyc("rf3_idle", E_ZERO);
      set_instr(7'b0000011, 3'b000, 1'b0);
      cyc("lwf3_fetch", e_fetch);
      cyc("lwf3_decode", e_decode);
      cyc("lwf3_trap", e_trap);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
